// File: rtl/ntt_bank_scheduler_if.sv
// ntt_bank_scheduler_if: handshake and group-output bundle between the NTT
// bank scheduler (master) and the butterfly datapath / crossbar (slave).
interface ntt_bank_scheduler_if #(
   parameter int ADDR_W = 6
);
   logic              start;
   logic              inv;
   logic              out_ready;
   logic              busy;
   logic              done;
   logic              out_valid;
   logic [ADDR_W-1:0] lane_addr_0;
   logic [ADDR_W-1:0] lane_addr_1;
   logic [ADDR_W-1:0] lane_addr_2;
   logic [ADDR_W-1:0] lane_addr_3;
   logic [1:0]        sel_a_0;
   logic [1:0]        sel_a_1;
   logic [1:0]        sel_a_2;
   logic [1:0]        sel_a_3;
   logic [6:0]        zeta_idx;
   logic [2:0]        layer;
   logic              last_in_layer;

   modport master (
      input  start, inv, out_ready,
      output busy, done, out_valid,
             lane_addr_0, lane_addr_1, lane_addr_2, lane_addr_3,
             sel_a_0, sel_a_1, sel_a_2, sel_a_3,
             zeta_idx, layer, last_in_layer
   );

   modport slave (
      output start, inv, out_ready,
      input  busy, done, out_valid,
             lane_addr_0, lane_addr_1, lane_addr_2, lane_addr_3,
             sel_a_0, sel_a_1, sel_a_2, sel_a_3,
             zeta_idx, layer, last_in_layer
   );
endinterface

// File: rtl/ntt_bank_scheduler.sv
// ntt_bank_scheduler: issues one conflict-free group of four coefficients
// (two radix-2 butterflies) per cycle across four 64-word banks, for all
// seven layers of a 256-point Kyber NTT or INTT. Banks are chosen by XOR of
// the base-4 digits of the coefficient index, which keeps every group
// spread over four distinct banks.
module ntt_bank_scheduler #(
   parameter int ADDR_W    = 6,
   parameter int LAYER_GAP = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   ntt_bank_scheduler_if.master bus
);

   typedef enum logic [1:0] {IDLE, RUN, GAP, FIN} state_t;

   localparam bit         HAS_GAP  = (LAYER_GAP > 0);
   localparam logic [3:0] GAP_LAST = HAS_GAP ? 4'(LAYER_GAP - 1) : 4'd0;

   // Sequencer state; layer_q/g_q always name the group being presented.
   state_t      state_q;
   logic        inv_q;
   logic [2:0]  layer_q;
   logic [5:0]  g_q;
   logic [3:0]  gap_cnt_q;

   // Registered outputs
   logic              valid_q;
   logic              busy_q;
   logic              done_q;
   logic              last_q;
   logic [ADDR_W-1:0] addr_q [4];
   logic [1:0]        sel_q  [4];
   logic [6:0]        zeta_q;

   // Next-group pointer and its decoded lanes
   logic [2:0]  nxt_layer;
   logic [5:0]  nxt_g;
   logic        end_of_layer;
   logic        load_grp;
   logic [3:0]  p;
   logic [8:0]  len;
   logic [8:0]  half;
   logic [8:0]  gv;
   logic [8:0]  j;
   logic [5:0]  grp_hi;
   logic [7:0]  idx   [4];
   logic [1:0]  bank  [4];
   logic [1:0]  sel_d [4];
   logic [6:0]  zeta_d;

   function automatic logic [1:0] bank_of(input logic [7:0] i);
      return i[1:0] ^ i[3:2] ^ i[5:4] ^ i[7:6];
   endfunction

   // Pick the group to load next and decide whether it is loaded this cycle.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      nxt_layer    = layer_q;
      nxt_g        = g_q;
      end_of_layer = &g_q;
      load_grp     = 1'b0;
      if (state_q == GAP || (state_q == RUN && valid_q && end_of_layer)) begin
         nxt_layer = layer_q + 3'd1;
         nxt_g     = '0;
      end else if (state_q == RUN && valid_q) begin
         nxt_g = g_q + 6'd1;
      end
      case (state_q)
         RUN:     load_grp = !valid_q ||
                             (bus.out_ready && !(end_of_layer && (layer_q == 3'd6 || HAS_GAP)));
         GAP:     load_grp = (gap_cnt_q == 4'd0);
         default: load_grp = 1'b0;
      endcase
   end

   // Decode the next group into lane indices, bank selects and twiddle index.
   always_comb begin
      p      = inv_q ? ({1'b0, nxt_layer} + 4'd1) : (4'd7 - {1'b0, nxt_layer});
      len    = 9'd1 << p;
      half   = len >> 1;
      gv     = {3'd0, nxt_g};
      grp_hi = 6'(gv >> (p - 4'd1));
      j      = ((gv >> (p - 4'd1)) << (p + 4'd1)) | (gv & (half - 9'd1));
      idx[0] = j[7:0];
      idx[1] = 8'(j + len);
      idx[2] = 8'(j + half);
      idx[3] = 8'(j + half + len);
      for (int k = 0; k < 4; k++) begin
         bank[k] = bank_of(idx[k]);
      end
      for (int k = 0; k < 4; k++) begin
         sel_d[k] = '0;
         for (int l = 0; l < 4; l++) begin
            if (bank[l] == 2'(k)) sel_d[k] = 2'(l);
         end
      end
      if (inv_q) zeta_d = 7'((8'd1 << (3'd7 - nxt_layer)) - 8'd1 - {2'd0, grp_hi});
      else       zeta_d = 7'((8'd1 << nxt_layer) + {2'd0, grp_hi});
   end

   // Sequencer FSM with registered group outputs.
   always_ff @(posedge clk) begin
      // NOTE: synchronous reset sampled on the edge; all state uses non-blocking assignments.
      if (!rst_n) begin
         state_q   <= IDLE;
         inv_q     <= 1'b0;
         layer_q   <= '0;
         g_q       <= '0;
         gap_cnt_q <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         last_q    <= 1'b0;
         zeta_q    <= '0;
         for (int k = 0; k < 4; k++) begin
            addr_q[k] <= '0;
            sel_q[k]  <= '0;
         end
      end else begin
         done_q <= 1'b0;
         if (load_grp) begin
            state_q <= RUN;
            layer_q <= nxt_layer;
            g_q     <= nxt_g;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            last_q  <= &nxt_g;
            zeta_q  <= zeta_d;
            for (int k = 0; k < 4; k++) begin
               addr_q[k] <= ADDR_W'(idx[k][7:2]);
               sel_q[k]  <= sel_d[k];
            end
         end else begin
            case (state_q)
               IDLE: begin
                  if (bus.start) begin
                     inv_q   <= bus.inv;
                     layer_q <= '0;
                     g_q     <= '0;
                     state_q <= RUN;
                  end
               end
               RUN: begin
                  // Reaching here with an accepted group means the layer just ended.
                  if (valid_q && bus.out_ready) begin
                     valid_q <= 1'b0;
                     if (layer_q == 3'd6) begin
                        state_q <= FIN;
                        done_q  <= 1'b1;
                     end else begin
                        state_q   <= GAP;
                        gap_cnt_q <= GAP_LAST;
                     end
                  end
               end
               GAP: gap_cnt_q <= gap_cnt_q - 4'd1;
               FIN: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
   assign bus.out_valid     = valid_q;
   assign bus.lane_addr_0   = addr_q[0];
   assign bus.lane_addr_1   = addr_q[1];
   assign bus.lane_addr_2   = addr_q[2];
   assign bus.lane_addr_3   = addr_q[3];
   assign bus.sel_a_0       = sel_q[0];
   assign bus.sel_a_1       = sel_q[1];
   assign bus.sel_a_2       = sel_q[2];
   assign bus.sel_a_3       = sel_q[3];
   assign bus.zeta_idx      = zeta_q;
   assign bus.layer         = layer_q;
   assign bus.last_in_layer = last_q;

endmodule

// File: tb/tb_ntt_bank_scheduler.sv
// tb_ntt_bank_scheduler: directed vectors plus full-transform sequences for
// the NTT bank scheduler, with LAYER_GAP = 4 and LAYER_GAP = 0 instances.
module tb_ntt_bank_scheduler;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   ntt_bank_scheduler_if #(.ADDR_W(6)) bus_a ();
   ntt_bank_scheduler_if #(.ADDR_W(6)) bus_z ();

   ntt_bank_scheduler #(.ADDR_W(6), .LAYER_GAP(4)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a)
   );

   ntt_bank_scheduler #(.ADDR_W(6), .LAYER_GAP(0)) dut_z (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_z)
   );

   typedef struct packed {
      logic [2:0] layer;
      logic [5:0] a0, a1, a2, a3;
      logic [1:0] s0, s1, s2, s3;
      logic [6:0] zeta;
      logic       last;
   } grp_t;

   typedef struct {
      logic inv;
      int   layer;
      int   g;
      int   a [4];
      int   s [4];
      int   zeta;
   } vec_t;

   int   checks = 0;
   int   errors = 0;
   vec_t tbl [7];
   grp_t cap [2][7][64];
   grp_t run_q [$];
   grp_t ref_q [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic grp_t snap_a();
      grp_t r;
      r.layer = bus_a.layer;
      r.a0 = bus_a.lane_addr_0; r.a1 = bus_a.lane_addr_1;
      r.a2 = bus_a.lane_addr_2; r.a3 = bus_a.lane_addr_3;
      r.s0 = bus_a.sel_a_0; r.s1 = bus_a.sel_a_1;
      r.s2 = bus_a.sel_a_2; r.s3 = bus_a.sel_a_3;
      r.zeta = bus_a.zeta_idx;
      r.last = bus_a.last_in_layer;
      return r;
   endfunction

   function automatic grp_t snap_z();
      grp_t r;
      r.layer = bus_z.layer;
      r.a0 = bus_z.lane_addr_0; r.a1 = bus_z.lane_addr_1;
      r.a2 = bus_z.lane_addr_2; r.a3 = bus_z.lane_addr_3;
      r.s0 = bus_z.sel_a_0; r.s1 = bus_z.sel_a_1;
      r.s2 = bus_z.sel_a_2; r.s3 = bus_z.sel_a_3;
      r.zeta = bus_z.zeta_idx;
      r.last = bus_z.last_in_layer;
      return r;
   endfunction

   // Reference group from the transform definition (len, j, digit-XOR bank).
   function automatic grp_t model(input logic inv_v, input int layer, input int g);
      int   len, p, d, j, b, zeta;
      int   idx [4];
      int   sel [4];
      grp_t r;
      len = inv_v ? (2 << layer) : (128 >> layer);
      p = $clog2(len);
      d = len / 2;
      j = ((g >> (p - 1)) << (p + 1)) | (g & ((1 << (p - 1)) - 1));
      idx[0] = j; idx[1] = j + len; idx[2] = j + d; idx[3] = j + d + len;
      for (int k = 0; k < 4; k++) begin
         sel[k] = 0;
         for (int l = 0; l < 4; l++) begin
            b = 0;
            for (int t = 0; t < 4; t++) b = b ^ ((idx[l] >> (2 * t)) & 3);
            if (b == k) sel[k] = l;
         end
      end
      zeta = inv_v ? (256 / len - 1 - j / (2 * len)) : (128 / len + j / (2 * len));
      r.layer = 3'(layer);
      r.a0 = 6'(idx[0] / 4); r.a1 = 6'(idx[1] / 4);
      r.a2 = 6'(idx[2] / 4); r.a3 = 6'(idx[3] / 4);
      r.s0 = 2'(sel[0]); r.s1 = 2'(sel[1]); r.s2 = 2'(sel[2]); r.s3 = 2'(sel[3]);
      r.zeta = 7'(zeta);
      r.last = (g == 63);
      return r;
   endfunction

   task automatic set_vec(input int n, input logic inv_v, input int layer, input int g,
                          input int a0, input int a1, input int a2, input int a3,
                          input int s0, input int s1, input int s2, input int s3, input int z);
      tbl[n].inv = inv_v; tbl[n].layer = layer; tbl[n].g = g;
      tbl[n].a[0] = a0; tbl[n].a[1] = a1; tbl[n].a[2] = a2; tbl[n].a[3] = a3;
      tbl[n].s[0] = s0; tbl[n].s[1] = s1; tbl[n].s[2] = s2; tbl[n].s[3] = s3;
      tbl[n].zeta = z;
   endtask

   // Full transform on the LAYER_GAP = 4 instance; records accepted groups.
   task automatic run_a(input logic inv_v, input bit throttle);
      int         n_vcyc, n_gap, n_done, n_acc, last_acc_cyc, dup, lyr, gi;
      bit         fin, done_seen, prev_stall;
      bit         used [7][4][64];
      grp_t       cur, prev, exp_g;
      logic [3:0] mask;
      int         la [4];
      int         sl [4];
      n_vcyc = 0; n_gap = 0; n_done = 0; n_acc = 0; last_acc_cyc = -10;
      fin = 1'b0; done_seen = 1'b0; prev_stall = 1'b0;
      prev = '0;
      for (int l = 0; l < 7; l++)
         for (int k = 0; k < 4; k++)
            for (int a = 0; a < 64; a++) used[l][k][a] = 1'b0;
      run_q.delete();
      @(negedge clk);
      bus_a.start = 1'b1; bus_a.inv = inv_v; bus_a.out_ready = 1'b1;
      @(negedge clk);
      bus_a.start = 1'b0; bus_a.inv = ~inv_v;
      check("pre_valid", 64'(bus_a.out_valid), 64'(0));
      check("pre_busy", 64'(bus_a.busy), 64'(0));
      for (int cyc = 0; cyc < 6000 && !fin; cyc++) begin
         @(negedge clk);
         cur = snap_a();
         if (done_seen) begin
            check("busy_after_done", 64'(bus_a.busy), 64'(0));
            check("done_width", 64'(bus_a.done), 64'(0));
            fin = 1'b1;
         end else begin
            if (cyc == 0) begin
               check("first_valid", 64'(bus_a.out_valid), 64'(1));
               check("first_busy", 64'(bus_a.busy), 64'(1));
               check("first_group", 64'(cur), 64'(model(inv_v, 0, 0)));
            end
            if (prev_stall) begin
               check("stall_valid", 64'(bus_a.out_valid), 64'(1));
               check("stall_hold", 64'(cur), 64'(prev));
            end
            if (bus_a.done) begin
               n_done++;
               done_seen = 1'b1;
               check("done_timing", 64'(last_acc_cyc), 64'(cyc - 1));
               check("done_valid", 64'(bus_a.out_valid), 64'(0));
            end else if (bus_a.busy && !bus_a.out_valid) begin
               n_gap++;
            end
            bus_a.out_ready = throttle ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus_a.start = (cyc == 150);
            prev_stall = 1'b0;
            if (bus_a.out_valid) begin
               n_vcyc++;
               if (bus_a.out_ready) begin
                  lyr = n_acc / 64;
                  gi = n_acc % 64;
                  exp_g = model(inv_v, lyr, gi);
                  check($sformatf("grp_l%0d_g%0d", lyr, gi), 64'(cur), 64'(exp_g));
                  la[0] = cur.a0; la[1] = cur.a1; la[2] = cur.a2; la[3] = cur.a3;
                  sl[0] = cur.s0; sl[1] = cur.s1; sl[2] = cur.s2; sl[3] = cur.s3;
                  mask = '0;
                  for (int k = 0; k < 4; k++) mask[sl[k]] = 1'b1;
                  check("bank_perm", 64'(mask), 64'(4'hf));
                  dup = 0;
                  if (lyr < 7) begin
                     for (int k = 0; k < 4; k++) begin
                        if (used[lyr][k][la[sl[k]]]) dup++;
                        used[lyr][k][la[sl[k]]] = 1'b1;
                     end
                     cap[inv_v][lyr][gi] = cur;
                  end
                  check("bank_addr_once", 64'(dup), 64'(0));
                  run_q.push_back(cur);
                  last_acc_cyc = cyc;
                  n_acc++;
               end else begin
                  prev_stall = 1'b1;
               end
            end
            prev = cur;
         end
      end
      bus_a.start = 1'b0;
      bus_a.out_ready = 1'b1;
      check("run_finished", 64'(fin), 64'(1));
      check("groups_accepted", 64'(n_acc), 64'(448));
      check("gap_cycles", 64'(n_gap), 64'(24));
      check("done_pulses", 64'(n_done), 64'(1));
      if (!throttle) check("valid_cycles", 64'(n_vcyc), 64'(448));
   endtask

   initial begin
      int   l3cnt, n_done, zacc, zbub, zdone;
      bit   found, after63, zfin;
      grp_t cur, e;

      // Directed vectors: inv, layer, group, lane_addr 0..3, sel_a 0..3, zeta_idx
      set_vec(0, 1'b0, 0,  0,  0, 32, 16, 48,  0, 2, 1, 3,   1);
      set_vec(1, 1'b0, 1, 33, 32, 48, 40, 56,  3, 2, 1, 0,   3);
      set_vec(2, 1'b0, 6,  5,  5,  5,  5,  5,  0, 2, 1, 3,  69);
      set_vec(3, 1'b1, 0,  5,  5,  5,  5,  5,  0, 2, 1, 3, 122);
      set_vec(4, 1'b0, 2, 10,  2, 10,  6, 14,  0, 2, 1, 3,   4);
      set_vec(5, 1'b0, 6, 63, 63, 63, 63, 63,  3, 1, 2, 0, 127);
      set_vec(6, 1'b1, 6,  0,  0, 32, 16, 48,  0, 2, 1, 3,   1);

      rst_n = 1'b0;
      bus_a.start = 1'b0; bus_a.inv = 1'b0; bus_a.out_ready = 1'b1;
      bus_z.start = 1'b0; bus_z.inv = 1'b0; bus_z.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_outputs_a", 64'({bus_a.busy, bus_a.done, bus_a.out_valid, snap_a()}), 64'(0));
      check("reset_outputs_z", 64'({bus_z.busy, bus_z.done, bus_z.out_valid, snap_z()}), 64'(0));
      rst_n = 1'b1;

      // Unthrottled forward and inverse transforms
      run_a(1'b0, 1'b0);
      ref_q = run_q;
      run_a(1'b1, 1'b0);

      for (int n = 0; n < 7; n++) begin
         e.layer = 3'(tbl[n].layer);
         e.a0 = 6'(tbl[n].a[0]); e.a1 = 6'(tbl[n].a[1]);
         e.a2 = 6'(tbl[n].a[2]); e.a3 = 6'(tbl[n].a[3]);
         e.s0 = 2'(tbl[n].s[0]); e.s1 = 2'(tbl[n].s[1]);
         e.s2 = 2'(tbl[n].s[2]); e.s3 = 2'(tbl[n].s[3]);
         e.zeta = 7'(tbl[n].zeta);
         e.last = (tbl[n].g == 63);
         check($sformatf("vec%0d", n), 64'(cap[tbl[n].inv][tbl[n].layer][tbl[n].g]), 64'(e));
      end

      // Throttled forward transform must accept the same group sequence
      run_a(1'b0, 1'b1);
      check("thr_len", 64'(run_q.size()), 64'(ref_q.size()));
      for (int i = 0; i < run_q.size() && i < ref_q.size(); i++)
         check($sformatf("thr_seq_%0d", i), 64'(run_q[i]), 64'(ref_q[i]));

      // Abort during layer 3
      @(negedge clk);
      bus_a.start = 1'b1; bus_a.inv = 1'b0;
      @(negedge clk);
      bus_a.start = 1'b0;
      found = 1'b0; l3cnt = 0;
      for (int cyc = 0; cyc < 2000 && !found; cyc++) begin
         @(negedge clk);
         if (bus_a.out_valid && bus_a.layer == 3'd3) begin
            l3cnt++;
            if (l3cnt == 10) found = 1'b1;
         end
      end
      check("reached_layer3", 64'(found), 64'(1));
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_outputs", 64'({bus_a.busy, bus_a.done, bus_a.out_valid, snap_a()}), 64'(0));
      rst_n = 1'b1;
      n_done = 0;
      repeat (30) begin
         @(negedge clk);
         if (bus_a.done) n_done++;
      end
      check("abort_no_done", 64'(n_done), 64'(0));
      check("abort_idle", 64'({bus_a.busy, bus_a.out_valid}), 64'(0));
      bus_a.start = 1'b1;
      @(negedge clk);
      bus_a.start = 1'b0;
      @(negedge clk);
      check("restart_valid", 64'(bus_a.out_valid), 64'(1));
      check("restart_group", 64'(snap_a()), 64'(model(1'b0, 0, 0)));

      // LAYER_GAP = 0: back-to-back layers
      @(negedge clk);
      bus_z.start = 1'b1;
      @(negedge clk);
      bus_z.start = 1'b0;
      zacc = 0; zbub = 0; zdone = 0; zfin = 1'b0; after63 = 1'b0;
      for (int cyc = 0; cyc < 2000 && !zfin; cyc++) begin
         @(negedge clk);
         cur = snap_z();
         if (after63) begin
            check("gap0_no_bubble", 64'(bus_z.out_valid), 64'(1));
            check("gap0_l1_g0", 64'(cur), 64'(model(1'b0, 1, 0)));
            after63 = 1'b0;
         end
         if (bus_z.done) begin
            zdone++;
            zfin = 1'b1;
         end else if (bus_z.busy && !bus_z.out_valid) begin
            zbub++;
         end
         if (bus_z.out_valid && bus_z.out_ready) begin
            if (zacc == 63) after63 = 1'b1;
            zacc++;
         end
      end
      check("gap0_finished", 64'(zfin), 64'(1));
      check("gap0_groups", 64'(zacc), 64'(448));
      check("gap0_bubbles", 64'(zbub), 64'(0));
      check("gap0_done", 64'(zdone), 64'(1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
